mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Memory-stage access controller. It consumes the outputs of the EX/MEM pipeline register and drives the multi-cycle data memory.
- It sequences each load or store through a registered request/done handshake.
- While an access is outstanding it holds the pipeline frozen via stall_pipe.
- It returns load data to MEM/WB and flags halt and error conditions for the hazard unit and the top level.

Parameters:
- DATA_W, 16, data and address width.
- TIMEOUT, 64, maximum WAIT cycles before an access is declared failed. Used only with WAIT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_in  in  DATA_W  effective address, taken from EX/MEM ALU output
- wdata_in  in  DATA_W  store data, taken from EX/MEM readData2 output
- memwrt_in  in  1  store request from EX/MEM
- memrd_in  in  1  load request from EX/MEM (decoded from RegSrc)
- halt_in  in  1  halt flag from EX/MEM
- nop_in  in  1  EX/MEM SendNOP; when 1 the slot is a bubble and all requests are ignored
- mem_en  out  1  memory request strobe, one cycle wide
- mem_wr  out  1  1 = write, 0 = read; meaningful only when mem_en=1
- mem_addr  out  DATA_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  read data, valid when mem_done=1
- mem_done  in  1  one-cycle completion pulse from memory
- mem_err  in  1  memory error, sampled only with mem_done or in WAIT
- stall_pipe  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- rdata_out  out  DATA_W  registered load data to MEM/WB
- halt_out  out  1  sticky halt indication
- err_out  out  1  sticky error indication
- err_code  out  2  00 none, 01 misaligned, 10 memory error, 11 timeout
- stall_cnt  out  16  saturating count of stall_pipe=1 cycles

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0: mem_en, mem_wr, mem_addr, mem_wdata, rdata_out, halt_out, err_out, err_code, stall_cnt.
  - Reset value appears in the cycle after a reset edge.
  - Reset in any state, including WAIT with a request outstanding, returns to IDLE. A late mem_done after reset is ignored.
- Access valid (acc): (memwrt_in | memrd_in) & !nop_in. If memwrt_in and memrd_in are both 1, treat the access as a store.
- IDLE:
  - acc & alu_in[0]=1 goes to ERR with err_code=01. No memory request is issued.
  - acc aligned:
    - Latch alu_in into mem_addr and wdata_in into mem_wdata.
    - Set mem_wr=memwrt_in.
    - stall_pipe=1 combinationally this cycle.
    - Go to ISSUE.
  - halt_in & !nop_in & !acc goes to HALTED.
  - Otherwise stay in IDLE with stall_pipe=0.
- ISSUE:
  - mem_en=1 for exactly this cycle; stall_pipe=1.
  - mem_done and mem_err are ignored in this cycle.
  - Go to WAIT.
- WAIT:
  - stall_pipe=1; mem_en=0.
  - mem_done & mem_err goes to ERR with err_code=10.
  - mem_done & !mem_err:
    - If the access was a load, rdata_out <= mem_rdata. A store leaves rdata_out unchanged.
    - Go to DONE.
- DONE:
  - stall_pipe=0 for one cycle; EX/MEM advances at the end of this cycle.
  - No new acceptance in this cycle. Go to IDLE.
- Latency:
  - Memory done D cycles after mem_en (D≥1) gives D+2 stall cycles.
  - The release cycle (DONE) comes D+2 cycles after acceptance.
- HALTED: sticky until rst. halt_out=1, stall_pipe=0, no requests issued.
- ERR: sticky until rst. err_out=1, stall_pipe=1, no requests issued.
- stall_cnt increments every cycle stall_pipe=1 and saturates at 16'hFFFF.

Optional Feature:
- Macro: WAIT_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT without mem_done, go to ERR with err_code=11.
  - A mem_done arriving in the same cycle the count reaches TIMEOUT wins: the access completes normally.
- Undefined: counter logic is absent, WAIT is unbounded, and err_code 11 is never produced.

Test Plan:
- Load at addr 16'h0010; memory returns 16'hBEEF with done 3 cycles after mem_en.
  - Required: mem_en for exactly 1 cycle, mem_wr=0.
  - stall_pipe=1 for 5 cycles.
  - DONE cycle has stall_pipe=0 and rdata_out=16'hBEEF.
  - stall_cnt=5.
- Store 16'h1234 to addr 16'h0022 with done 1 cycle after mem_en.
  - Required: mem_wr=1, mem_addr=16'h0022, mem_wdata=16'h1234.
  - 3 stall cycles; rdata_out unchanged.
- Load to addr 16'h0013.
  - Required: no mem_en.
  - err_out=1, err_code=01, stall_pipe stays 1 until rst.
- nop_in=1 with memrd_in=1 and halt_in=1.
  - Required: no request, no halt, stall_pipe=0.
- halt_in=1 with nop_in=0.
  - Required: halt_out=1 the next cycle; a following memwrt_in is ignored.
- rst asserted in WAIT, then mem_done pulsed.
  - Required: IDLE, all outputs 0, rdata_out stays 0.
  - With WAIT_TIMEOUT_EN and TIMEOUT=4, no done gives err_code=11 after 4 WAIT cycles.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns EX/MEM load/store requests into a one-cycle request to a
// multi-cycle data memory and freezes the pipeline until it completes. Optional WAIT watchdog: WAIT_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              memwrt_in,
    input  logic              memrd_in,
    input  logic              halt_in,
    input  logic              nop_in,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic              mem_err,
    output logic              stall_pipe,
    output logic [DATA_W-1:0] rdata_out,
    output logic              halt_out,
    output logic              err_out,
    output logic [1:0]        err_code,
    output logic [15:0]       stall_cnt
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        HALTED,
        ERR
    } state_t;

    state_t            state_reg;
    logic              mem_en_reg;
    logic              mem_wr_reg;
    logic [DATA_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              halt_reg;
    logic              err_reg;
    logic [1:0]        code_reg;
    logic [15:0]       stall_cnt_reg;
    logic              acc;

`ifdef WAIT_TIMEOUT_EN
    // Counter holds the number of WAIT cycles already spent, 0..TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt_reg;
`else
    generate
        if (TIMEOUT < 1) begin : g_timeout_unused
        end
    endgenerate
`endif

    // A store wins when both request bits are set, so mem_wr simply follows memwrt_in.
    assign acc = (memwrt_in | memrd_in) & ~nop_in;

    always_comb begin
        stall_pipe = 1'b0;
        case (state_reg)
            IDLE:              stall_pipe = acc;
            ISSUE, WAIT, ERR:  stall_pipe = 1'b1;
            default:           stall_pipe = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mem_en_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            halt_reg      <= 1'b0;
            err_reg       <= 1'b0;
            code_reg      <= 2'b00;
            stall_cnt_reg <= '0;
`ifdef WAIT_TIMEOUT_EN
            wait_cnt_reg  <= '0;
`endif
        end else begin
            mem_en_reg <= 1'b0;
            if (stall_pipe && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (acc) begin
                        if (alu_in[0]) begin
                            state_reg <= ERR;
                            err_reg   <= 1'b1;
                            code_reg  <= 2'b01;
                        end else begin
                            addr_reg   <= alu_in;
                            wdata_reg  <= wdata_in;
                            mem_wr_reg <= memwrt_in;
                            mem_en_reg <= 1'b1;
                            state_reg  <= ISSUE;
                        end
                    end else if (halt_in && !nop_in) begin
                        state_reg <= HALTED;
                        halt_reg  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
`ifdef WAIT_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                WAIT: begin
                    if (mem_done) begin
                        if (mem_err) begin
                            state_reg <= ERR;
                            err_reg   <= 1'b1;
                            code_reg  <= 2'b10;
                        end else begin
                            if (!mem_wr_reg) begin
                                rdata_reg <= mem_rdata;
                            end
                            state_reg <= DONE;
                        end
                    end
`ifdef WAIT_TIMEOUT_EN
                    // A done in the final allowed cycle is taken above and beats the timeout.
                    else if (wait_cnt_reg == LAST_WAIT) begin
                        state_reg <= ERR;
                        err_reg   <= 1'b1;
                        code_reg  <= 2'b11;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                DONE:    state_reg <= IDLE;
                HALTED:  state_reg <= HALTED;
                ERR:     state_reg <= ERR;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_en    = mem_en_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign rdata_out = rdata_reg;
    assign halt_out  = halt_reg;
    assign err_out   = err_reg;
    assign err_code  = code_reg;
    assign stall_cnt = stall_cnt_reg;
endmodule
